hazard_unit: RTL and testbench

- Producer of the `pause` input of the ID/EXE pipeline register, plus the stall and flush controls for PC and IF/ID.
- Holds a 3-entry shadow scoreboard mirroring the instructions in EXE, MEM and WB.
- Detects RAW hazards between the instruction in ID and those in-flight writers, and detects taken branches resolved in EXE.
- Drives bubble insertion, front-end freeze and flush, and keeps two saturating performance counters.

---
 rtl/hazard_unit_pkg.sv | 21 ++
 rtl/hazard_sb_stage.sv | 29 ++
 rtl/hazard_unit.sv | 142 ++++++++++++++
 tb/tb_hazard_unit.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_unit_pkg.sv
// rtl/hazard_unit_pkg.sv - shared constants and scoreboard entry layout for the hazard unit
package hazard_unit_pkg;

  localparam int REG_ADDR_W = 5;

  localparam int WDATA_SRC_LENGTH = 2;
  localparam logic [WDATA_SRC_LENGTH-1:0] WDATA_SRC_ALU = 2'd0;
  localparam logic [WDATA_SRC_LENGTH-1:0] WDATA_SRC_MEM = 2'd1;

  localparam int SB_V_W     = 1;
  localparam int SB_LD_W    = 1;
  localparam int SB_DST_W   = REG_ADDR_W;
  localparam int SB_ENTRY_W = SB_V_W + SB_LD_W + SB_DST_W;

  typedef struct packed {
    logic                v;
    logic                ld;
    logic [SB_DST_W-1:0] dst;
  } sb_entry_t;

endpackage

// File: rtl/hazard_sb_stage.sv
// rtl/hazard_sb_stage.sv - one scoreboard entry register that loads a bubble on request
module hazard_sb_stage
  import hazard_unit_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  bubble,
  input  logic [SB_ENTRY_W-1:0] entry_in,
  output logic [SB_ENTRY_W-1:0] entry_out
);

  logic [SB_ENTRY_W-1:0] entry_d;
  logic [SB_ENTRY_W-1:0] entry_q;

  always_comb begin
    entry_d = bubble ? '0 : entry_in;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      entry_q <= '0;
    end else begin
      entry_q <= entry_d;
    end
  end

  assign entry_out = entry_q;

endmodule

// File: rtl/hazard_unit.sv
// rtl/hazard_unit.sv - RAW and taken-branch hazard detection driving stall, flush and bubble controls
module hazard_unit
  import hazard_unit_pkg::*;
#(
  parameter int FORWARDING = 1,
  parameter int WB_BYPASS  = 1,
  parameter int CNT_W      = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        id_valid,
  input  logic [REG_ADDR_W-1:0]       id_rs_addr,
  input  logic                        id_rs_used,
  input  logic [REG_ADDR_W-1:0]       id_rt_addr,
  input  logic                        id_rt_used,
  input  logic                        id_reg_we,
  input  logic [REG_ADDR_W-1:0]       id_wdst,
  input  logic [WDATA_SRC_LENGTH-1:0] id_wdata_src,
  input  logic                        exe_branch_taken,
  output logic                        pc_stall,
  output logic                        if_id_stall,
  output logic                        if_id_flush,
  output logic                        id_exe_pause,
  output logic [CNT_W-1:0]            stall_cnt,
  output logic [CNT_W-1:0]            flush_cnt
);

  sb_entry_t             sb_new;
  sb_entry_t             sb_exe;
  sb_entry_t             sb_mem;
  sb_entry_t             sb_wb;
  logic [SB_ENTRY_W-1:0] sb_exe_bits;
  logic [SB_ENTRY_W-1:0] sb_mem_bits;
  logic [SB_ENTRY_W-1:0] sb_wb_bits;
  logic                  raw_exe;
  logic                  raw_mem;
  logic                  raw_wb;
  logic                  hz;
  logic                  stall;
  logic                  unused_wb_ld;
  logic [CNT_W-1:0]      stall_cnt_d;
  logic [CNT_W-1:0]      stall_cnt_q;
  logic [CNT_W-1:0]      flush_cnt_d;
  logic [CNT_W-1:0]      flush_cnt_q;

  function automatic logic raw_hit(input sb_entry_t s,
                                   input logic rs_used, input logic [REG_ADDR_W-1:0] rs,
                                   input logic rt_used, input logic [REG_ADDR_W-1:0] rt);
    return s.v & ((rs_used & (rs == s.dst)) | (rt_used & (rt == s.dst)));
  endfunction

  // Register 0 is never recorded as a writer, so it can never match.
  always_comb begin
    sb_new     = '0;
    sb_new.v   = id_valid & id_reg_we & (id_wdst != '0);
    sb_new.ld  = (id_wdata_src == WDATA_SRC_MEM);
    sb_new.dst = id_wdst;
  end

  hazard_sb_stage u_sb_exe (
    .clk       (clk),
    .rst       (rst),
    .bubble    (id_exe_pause),
    .entry_in  (sb_new),
    .entry_out (sb_exe_bits)
  );

  hazard_sb_stage u_sb_mem (
    .clk       (clk),
    .rst       (rst),
    .bubble    (1'b0),
    .entry_in  (sb_exe_bits),
    .entry_out (sb_mem_bits)
  );

  hazard_sb_stage u_sb_wb (
    .clk       (clk),
    .rst       (rst),
    .bubble    (1'b0),
    .entry_in  (sb_mem_bits),
    .entry_out (sb_wb_bits)
  );

  assign sb_exe       = sb_exe_bits;
  assign sb_mem       = sb_mem_bits;
  assign sb_wb        = sb_wb_bits;
  assign unused_wb_ld = sb_wb.ld;

  always_comb begin
    raw_exe = raw_hit(sb_exe, id_rs_used, id_rs_addr, id_rt_used, id_rt_addr);
    raw_mem = raw_hit(sb_mem, id_rs_used, id_rs_addr, id_rt_used, id_rt_addr);
    raw_wb  = raw_hit(sb_wb,  id_rs_used, id_rs_addr, id_rt_used, id_rt_addr);
    if (FORWARDING != 0) begin
      hz = raw_exe & sb_exe.ld;
    end else begin
      hz = raw_exe | raw_mem | (raw_wb & (WB_BYPASS == 0));
    end
    stall = id_valid & hz;
  end

  // A taken branch squashes the ID instruction, so it wins over any stall.
  always_comb begin
    pc_stall     = 1'b0;
    if_id_stall  = 1'b0;
    if_id_flush  = 1'b0;
    id_exe_pause = 1'b0;
    if (!rst) begin
      if (exe_branch_taken) begin
        if_id_flush  = 1'b1;
        id_exe_pause = 1'b1;
      end else if (stall) begin
        pc_stall     = 1'b1;
        if_id_stall  = 1'b1;
        id_exe_pause = 1'b1;
      end
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (exe_branch_taken) begin
      if (flush_cnt_q != '1) flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end else if (stall) begin
      if (stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_hazard_unit.sv
// tb/tb_hazard_unit.sv - randomized and directed self-checking bench for hazard_unit
module tb_hazard_unit;
  import hazard_unit_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1;
  logic       id_valid = 1'b0;
  logic [4:0] id_rs_addr = '0;
  logic       id_rs_used = 1'b0;
  logic [4:0] id_rt_addr = '0;
  logic       id_rt_used = 1'b0;
  logic       id_reg_we = 1'b0;
  logic [4:0] id_wdst = '0;
  logic [1:0] id_wdata_src = '0;
  logic       exe_branch_taken = 1'b0;

  logic [2:0]  pc_s, ifs_s, ifl_s, pau_s;
  logic [31:0] sc_a, fc_a, sc_b, fc_b;
  logic [3:0]  sc_c, fc_c;

  int  n_vec = 0;
  int  n_bad = 0;
  bit  chk_en = 1'b0;

  hazard_unit #(.FORWARDING(1), .WB_BYPASS(1), .CNT_W(32)) u_a (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs_addr(id_rs_addr), .id_rs_used(id_rs_used),
    .id_rt_addr(id_rt_addr), .id_rt_used(id_rt_used), .id_reg_we(id_reg_we), .id_wdst(id_wdst),
    .id_wdata_src(id_wdata_src), .exe_branch_taken(exe_branch_taken),
    .pc_stall(pc_s[0]), .if_id_stall(ifs_s[0]), .if_id_flush(ifl_s[0]), .id_exe_pause(pau_s[0]),
    .stall_cnt(sc_a), .flush_cnt(fc_a));

  hazard_unit #(.FORWARDING(0), .WB_BYPASS(1), .CNT_W(32)) u_b (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs_addr(id_rs_addr), .id_rs_used(id_rs_used),
    .id_rt_addr(id_rt_addr), .id_rt_used(id_rt_used), .id_reg_we(id_reg_we), .id_wdst(id_wdst),
    .id_wdata_src(id_wdata_src), .exe_branch_taken(exe_branch_taken),
    .pc_stall(pc_s[1]), .if_id_stall(ifs_s[1]), .if_id_flush(ifl_s[1]), .id_exe_pause(pau_s[1]),
    .stall_cnt(sc_b), .flush_cnt(fc_b));

  hazard_unit #(.FORWARDING(0), .WB_BYPASS(0), .CNT_W(4)) u_c (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs_addr(id_rs_addr), .id_rs_used(id_rs_used),
    .id_rt_addr(id_rt_addr), .id_rt_used(id_rt_used), .id_reg_we(id_reg_we), .id_wdst(id_wdst),
    .id_wdata_src(id_wdata_src), .exe_branch_taken(exe_branch_taken),
    .pc_stall(pc_s[2]), .if_id_stall(ifs_s[2]), .if_id_flush(ifl_s[2]), .id_exe_pause(pau_s[2]),
    .stall_cnt(sc_c), .flush_cnt(fc_c));

  // Reference model: per instance, a history of the last three issued instructions
  // (index 0 = youngest, in EXE) and plain saturating counters.
  logic       m_w   [3][3];
  logic       m_ld  [3][3];
  logic [4:0] m_dst [3][3];
  longint     m_sc  [3] = '{0, 0, 0};
  longint     m_fc  [3] = '{0, 0, 0};
  longint     m_max [3] = '{64'hFFFF_FFFF, 64'hFFFF_FFFF, 15};
  logic       mp, ms;

  function automatic logic m_reads(input logic [4:0] r);
    return (id_rs_used && id_rs_addr == r) || (id_rt_used && id_rt_addr == r);
  endfunction

  // Forwarding: only a load one instruction ahead hurts. Without forwarding, any writer
  // still within reach of the register file read (2 older slots with write-through, 3 without).
  function automatic logic m_stall(input int k);
    int   depth;
    logic h;
    h = 1'b0;
    if (!id_valid) return 1'b0;
    if (k == 0) return m_w[0][0] && m_ld[0][0] && m_reads(m_dst[0][0]);
    depth = (k == 1) ? 2 : 3;
    for (int d = 0; d < depth; d++)
      if (m_w[k][d] && m_reads(m_dst[k][d])) h = 1'b1;
    return h;
  endfunction

  // {pc_stall, if_id_stall, if_id_flush, id_exe_pause}
  function automatic logic [3:0] m_ctl(input int k);
    if (rst) return 4'b0000;
    if (exe_branch_taken) return 4'b0011;
    if (m_stall(k)) return 4'b1101;
    return 4'b0000;
  endfunction

  function automatic logic [3:0] ctl(input int k);
    return {pc_s[k], ifs_s[k], ifl_s[k], pau_s[k]};
  endfunction

  function automatic longint dut_sc(input int k);
    return (k == 0) ? longint'(sc_a) : (k == 1) ? longint'(sc_b) : longint'(sc_c);
  endfunction

  function automatic longint dut_fc(input int k);
    return (k == 0) ? longint'(fc_a) : (k == 1) ? longint'(fc_b) : longint'(fc_c);
  endfunction

  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (rst) begin
        for (int d = 0; d < 3; d++) begin
          m_w[k][d] = 1'b0; m_ld[k][d] = 1'b0; m_dst[k][d] = '0;
        end
        m_sc[k] = 0;
        m_fc[k] = 0;
      end else begin
        mp = exe_branch_taken || m_stall(k);
        ms = m_stall(k);
        if (exe_branch_taken) begin
          if (m_fc[k] < m_max[k]) m_fc[k] = m_fc[k] + 1;
        end else if (ms) begin
          if (m_sc[k] < m_max[k]) m_sc[k] = m_sc[k] + 1;
        end
        for (int d = 2; d > 0; d--) begin
          m_w[k][d] = m_w[k][d-1]; m_ld[k][d] = m_ld[k][d-1]; m_dst[k][d] = m_dst[k][d-1];
        end
        m_w[k][0]   = !mp && id_valid && id_reg_we && (id_wdst != 0);
        m_ld[k][0]  = (id_wdata_src == WDATA_SRC_MEM);
        m_dst[k][0] = id_wdst;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < 3; k++) begin
        n_vec++;
        if (ctl(k) !== m_ctl(k)) begin
          n_bad++;
          $display("FAIL ctl inst%0d t=%0t got %b expected %b", k, $time, ctl(k), m_ctl(k));
        end
        n_vec++;
        if (dut_sc(k) != m_sc[k]) begin
          n_bad++;
          $display("FAIL stall_cnt inst%0d t=%0t got %0d expected %0d", k, $time, dut_sc(k), m_sc[k]);
        end
        n_vec++;
        if (dut_fc(k) != m_fc[k]) begin
          n_bad++;
          $display("FAIL flush_cnt inst%0d t=%0t got %0d expected %0d", k, $time, dut_fc(k), m_fc[k]);
        end
      end
    end
  end

  task automatic chk(input string name, input longint act, input longint exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic at_sample();
    @(negedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [4:0] rs, input logic rsu, input logic [4:0] rt,
                       input logic rtu, input logic we, input logic [4:0] dst, input logic ld,
                       input logic br);
    id_valid = v; id_rs_addr = rs; id_rs_used = rsu; id_rt_addr = rt; id_rt_used = rtu;
    id_reg_we = we; id_wdst = dst; id_wdata_src = ld ? WDATA_SRC_MEM : WDATA_SRC_ALU;
    exe_branch_taken = br;
  endtask

  task automatic nop();
    drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    nop();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    do_reset();
    chk_en = 1'b1;
    at_sample();
    chk("reset ctl a", ctl(0), 0);
    chk("reset stall_cnt a", sc_a, 0);
    chk("reset flush_cnt a", fc_a, 0);

    // load-use with forwarding: one bubble, then release
    tick();
    drive(1, 0, 0, 0, 0, 1, 5, 1, 0);
    tick();
    drive(1, 5, 1, 2, 1, 1, 6, 0, 0);
    at_sample();
    chk("load-use stall a", ctl(0), 4'b1101);
    tick();
    at_sample();
    chk("load-use release a", ctl(0), 4'b0000);
    chk("load-use stall_cnt a", sc_a, 1);
    chk("model stall_cnt a", m_sc[0], 1);

    // no false hazards: ALU result forwarded, and r0 never pending
    do_reset();
    drive(1, 0, 0, 0, 0, 1, 5, 0, 0);
    tick();
    drive(1, 5, 1, 0, 0, 1, 6, 0, 0);
    at_sample();
    chk("alu-use no stall a", ctl(0), 4'b0000);
    do_reset();
    drive(1, 0, 0, 0, 0, 1, 0, 1, 0);
    tick();
    drive(1, 0, 1, 0, 1, 1, 6, 0, 0);
    at_sample();
    chk("r0 no stall a", ctl(0), 4'b0000);
    chk("r0 no stall c", ctl(2), 4'b0000);

    // no forwarding: 2 stall cycles with write-through, 3 without
    do_reset();
    drive(1, 0, 0, 0, 0, 1, 7, 0, 0);
    tick();
    drive(1, 1, 1, 7, 1, 1, 8, 0, 0);
    for (int i = 0; i < 4; i++) begin
      at_sample();
      chk($sformatf("nofwd wt cyc%0d b", i), ctl(1), (i < 2) ? 4'b1101 : 4'b0000);
      chk($sformatf("nofwd cyc%0d c", i), ctl(2), (i < 3) ? 4'b1101 : 4'b0000);
      tick();
      if (i >= 2) nop();
    end
    chk("nofwd stall_cnt c", sc_c, 3);
    chk("nofwd stall_cnt b", sc_b, 2);

    // branch overrides a simultaneous load-use stall
    do_reset();
    drive(1, 0, 0, 0, 0, 1, 5, 1, 0);
    tick();
    drive(1, 5, 1, 0, 0, 1, 6, 0, 1);
    at_sample();
    chk("branch over stall a", ctl(0), 4'b0011);
    tick();
    nop();
    at_sample();
    chk("branch flush_cnt a", fc_a, 1);
    chk("branch stall_cnt a", sc_a, 0);

    // reset asserted during a stall
    tick();
    drive(1, 0, 0, 0, 0, 1, 5, 1, 0);
    tick();
    drive(1, 5, 1, 0, 0, 1, 6, 0, 0);
    at_sample();
    chk("pre-reset stall a", ctl(0), 4'b1101);
    rst = 1'b1;
    #1;
    chk("reset gates stall a", ctl(0), 4'b0000);
    tick();
    rst = 1'b0;
    at_sample();
    chk("post-reset stall_cnt a", sc_a, 0);
    chk("post-reset flush_cnt a", fc_a, 0);
    chk("post-reset reader a", ctl(0), 4'b0000);
    chk("post-reset reader c", ctl(2), 4'b0000);

    // saturation on the narrow-counter instance
    do_reset();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
    repeat (20) tick();
    drive(1, 7, 1, 0, 0, 1, 7, 0, 0);
    at_sample();
    chk("flush sat c", fc_c, 15);
    chk("model flush sat c", m_fc[2], 15);
    repeat (40) tick();
    at_sample();
    chk("stall sat c", sc_c, 15);
    chk("flush sat hold c", fc_c, 15);
    chk("model stall sat c", m_sc[2], 15);

    // randomized traffic against the model
    tick();
    for (int i = 0; i < 3000; i++) begin
      rst              = ($urandom_range(0, 99) < 2);
      id_valid         = ($urandom_range(0, 9) != 0);
      id_rs_addr       = 5'($urandom_range(0, 7));
      id_rs_used       = $urandom_range(0, 1) == 1;
      id_rt_addr       = 5'($urandom_range(0, 7));
      id_rt_used       = $urandom_range(0, 1) == 1;
      id_reg_we        = ($urandom_range(0, 3) != 0);
      id_wdst          = 5'($urandom_range(0, 7));
      id_wdata_src     = 2'($urandom_range(0, 3));
      exe_branch_taken = ($urandom_range(0, 9) == 0);
      tick();
    end
    rst = 1'b0;
    nop();
    at_sample();
    chk_en = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
